// File: rtl/wrap_queue_ctrl_if.sv
// Enqueue/dequeue handshake and storage-index bundle for wrap_queue_ctrl.
// Optional WRAP_QUEUE_CTRL_ROLLBACK_EN adds the rollback request signals.
interface wrap_queue_ctrl_if #(
    parameter int unsigned NBITS = 2,
    parameter int unsigned CBITS = 3
);
    logic             enq_val;
    logic             enq_rdy;
    logic             deq_val;
    logic             deq_rdy;
    logic             wr_en;
    logic [NBITS-1:0] wr_idx;
    logic [NBITS-1:0] rd_idx;
    logic [CBITS-1:0] count;
    logic             full;
    logic             empty;
`ifdef WRAP_QUEUE_CTRL_ROLLBACK_EN
    logic             rollback_val;
    logic [NBITS-1:0] rollback_idx;

    modport master (
        output enq_val, deq_rdy, rollback_val, rollback_idx,
        input  enq_rdy, deq_val, wr_en, wr_idx, rd_idx, count, full, empty
    );
    modport slave (
        input  enq_val, deq_rdy, rollback_val, rollback_idx,
        output enq_rdy, deq_val, wr_en, wr_idx, rd_idx, count, full, empty
    );
`else
    modport master (
        output enq_val, deq_rdy,
        input  enq_rdy, deq_val, wr_en, wr_idx, rd_idx, count, full, empty
    );
    modport slave (
        input  enq_val, deq_rdy,
        output enq_rdy, deq_val, wr_en, wr_idx, rd_idx, count, full, empty
    );
`endif
endinterface

// File: rtl/wrap_queue_ctrl.sv
// Head/tail/occupancy controller for a SIZE-entry ring beside an external storage array.
// Define WRAP_QUEUE_CTRL_ROLLBACK_EN to enable tail rollback (squash of younger entries).
module wrap_queue_ctrl #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned NBITS = 2,
    parameter int unsigned CBITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    wrap_queue_ctrl_if.slave   q
);
    logic [NBITS-1:0] head;
    logic [NBITS-1:0] tail;
    logic [CBITS-1:0] cnt;

    logic             full_c;
    logic             empty_c;
    logic             rb_c;
    logic [NBITS-1:0] rb_idx_c;
    logic             enq_rdy_c;
    logic             deq_val_c;
    logic             enq_fire_c;
    logic             deq_fire_c;
    logic [NBITS-1:0] head_nxt;
    logic [NBITS-1:0] tail_nxt;
    logic [CBITS-1:0] cnt_nxt;

    // Explicit compare so non-power-of-two rings never visit indices >= SIZE.
    function automatic logic [NBITS-1:0] wrap_inc(input logic [NBITS-1:0] x);
        return (x == NBITS'(SIZE - 1)) ? '0 : x + NBITS'(1);
    endfunction

`ifdef WRAP_QUEUE_CTRL_ROLLBACK_EN
    assign rb_c     = q.rollback_val;
    assign rb_idx_c = q.rollback_idx;
`else
    assign rb_c     = 1'b0;
    assign rb_idx_c = '0;
`endif

    assign full_c     = (cnt == CBITS'(SIZE));
    assign empty_c    = (cnt == '0);
    assign enq_rdy_c  = !full_c && !rb_c;
    assign deq_val_c  = !empty_c && !rb_c;
    assign enq_fire_c = q.enq_val && enq_rdy_c;
    assign deq_fire_c = deq_val_c && q.deq_rdy;

    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        cnt_nxt  = cnt;
        if (rb_c) begin
            tail_nxt = rb_idx_c;
            // Ring distance head->rollback_idx; equal-to-tail is a no-op (covers full ring).
            if (rb_idx_c == tail) begin
                cnt_nxt = cnt;
            end else if (rb_idx_c >= head) begin
                cnt_nxt = CBITS'(rb_idx_c) - CBITS'(head);
            end else begin
                cnt_nxt = CBITS'(SIZE) + CBITS'(rb_idx_c) - CBITS'(head);
            end
        end else begin
            if (enq_fire_c) tail_nxt = wrap_inc(tail);
            if (deq_fire_c) head_nxt = wrap_inc(head);
            case ({enq_fire_c, deq_fire_c})
                2'b10:   cnt_nxt = cnt + CBITS'(1);
                2'b01:   cnt_nxt = cnt - CBITS'(1);
                default: cnt_nxt = cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Write strobe is suppressed on a reset edge so storage never sees a discarded enqueue.
    assign q.wr_en   = enq_fire_c && reset;
    assign q.wr_idx  = tail;
    assign q.rd_idx  = head;
    assign q.count   = cnt;
    assign q.full    = full_c;
    assign q.empty   = empty_c;
    assign q.enq_rdy = enq_rdy_c;
    assign q.deq_val = deq_val_c;
endmodule

// File: tb/tb_wrap_queue_ctrl.sv
// Directed, table-driven check of wrap_queue_ctrl (SIZE=4 and SIZE=3 instances).
module tb_wrap_queue_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wrap_queue_ctrl_if #(.NBITS(2), .CBITS(3)) q4 ();
    wrap_queue_ctrl_if #(.NBITS(2), .CBITS(2)) q3 ();

    wrap_queue_ctrl #(.SIZE(4), .NBITS(2), .CBITS(3)) u4 (.clk(clk), .reset(reset), .q(q4.slave));
    wrap_queue_ctrl #(.SIZE(3), .NBITS(2), .CBITS(2)) u3 (.clk(clk), .reset(reset), .q(q3.slave));

    typedef struct {
        logic       enq;
        logic       deq;
        logic       wr_en;
        logic [1:0] wi;
        logic [1:0] ri;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       er;
        logic       dv;
    } vec_t;

    localparam int unsigned NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int e, input int d, input int we, input int wi, input int ri,
                                input int c, input int f, input int em, input int er, input int dv);
        vec_t v;
        v.enq = 1'(e); v.deq = 1'(d); v.wr_en = 1'(we); v.wi = 2'(wi); v.ri = 2'(ri);
        v.cnt = 3'(c); v.full = 1'(f); v.empty = 1'(em); v.er = 1'(er); v.dv = 1'(dv);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk4(input string nm, input vec_t v);
        chk({nm, ".wr_en"},   32'(q4.wr_en),   32'(v.wr_en));
        chk({nm, ".wr_idx"},  32'(q4.wr_idx),  32'(v.wi));
        chk({nm, ".rd_idx"},  32'(q4.rd_idx),  32'(v.ri));
        chk({nm, ".count"},   32'(q4.count),   32'(v.cnt));
        chk({nm, ".full"},    32'(q4.full),    32'(v.full));
        chk({nm, ".empty"},   32'(q4.empty),   32'(v.empty));
        chk({nm, ".enq_rdy"}, 32'(q4.enq_rdy), 32'(v.er));
        chk({nm, ".deq_val"}, 32'(q4.deq_val), 32'(v.dv));
    endtask

    initial begin
        // Expected values are for the cycle in which the inputs are applied (pre-edge state).
        vecs[0]  = mk(0,0, 0,0,0,0, 0,1,1,0);
        vecs[1]  = mk(1,0, 1,0,0,0, 0,1,1,0);
        vecs[2]  = mk(1,0, 1,1,0,1, 0,0,1,1);
        vecs[3]  = mk(1,0, 1,2,0,2, 0,0,1,1);
        vecs[4]  = mk(1,0, 1,3,0,3, 0,0,1,1);
        vecs[5]  = mk(1,0, 0,0,0,4, 1,0,0,1);
        vecs[6]  = mk(1,1, 0,0,0,4, 1,0,0,1);
        vecs[7]  = mk(0,0, 0,0,1,3, 0,0,1,1);
        vecs[8]  = mk(0,1, 0,0,1,3, 0,0,1,1);
        vecs[9]  = mk(0,1, 0,0,2,2, 0,0,1,1);
        vecs[10] = mk(1,0, 1,0,3,1, 0,0,1,1);
        vecs[11] = mk(1,1, 1,1,3,2, 0,0,1,1);
        vecs[12] = mk(1,1, 1,2,0,2, 0,0,1,1);
        vecs[13] = mk(1,1, 1,3,1,2, 0,0,1,1);
        vecs[14] = mk(0,0, 0,0,2,2, 0,0,1,1);
        vecs[15] = mk(0,1, 0,0,2,2, 0,0,1,1);
        vecs[16] = mk(0,1, 0,0,3,1, 0,0,1,1);
        vecs[17] = mk(0,1, 0,0,0,0, 0,1,1,0);

        reset = 1'b0;
        q4.enq_val = 1'b0; q4.deq_rdy = 1'b0;
        q3.enq_val = 1'b0; q3.deq_rdy = 1'b0;
`ifdef WRAP_QUEUE_CTRL_ROLLBACK_EN
        q4.rollback_val = 1'b0; q4.rollback_idx = '0;
        q3.rollback_val = 1'b0; q3.rollback_idx = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst.count",   32'(q4.count),   0);
        chk("rst.empty",   32'(q4.empty),   1);
        chk("rst.enq_rdy", 32'(q4.enq_rdy), 1);
        chk("rst.deq_val", 32'(q4.deq_val), 0);
        chk("rst.wr_idx",  32'(q4.wr_idx),  0);
        chk("rst.rd_idx",  32'(q4.rd_idx),  0);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            q4.enq_val = vecs[i].enq;
            q4.deq_rdy = vecs[i].deq;
            #1;
            chk4($sformatf("v%0d", i), vecs[i]);
        end

        // Reset with an enqueue pending: no write strobe, state cleared.
        @(negedge clk);
        q4.enq_val = 1'b1; q4.deq_rdy = 1'b0;
        #1 chk("mrst.pre_wr_en", 32'(q4.wr_en), 1);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mrst.wr_en", 32'(q4.wr_en), 0);
        @(negedge clk);
        reset = 1'b1; q4.enq_val = 1'b0;
        #1;
        chk("mrst.count",  32'(q4.count),  0);
        chk("mrst.wr_idx", 32'(q4.wr_idx), 0);
        chk("mrst.empty",  32'(q4.empty),  1);

`ifdef WRAP_QUEUE_CTRL_ROLLBACK_EN
        // Build head=1, tail=0, count=3 then roll tail back to 2.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            q4.enq_val = 1'b1;
        end
        @(negedge clk);
        q4.enq_val = 1'b0; q4.deq_rdy = 1'b1;
        @(negedge clk);
        q4.deq_rdy = 1'b0;
        #1;
        chk("rb.pre_count", 32'(q4.count),  3);
        chk("rb.pre_head",  32'(q4.rd_idx), 1);
        @(negedge clk);
        q4.enq_val = 1'b1; q4.deq_rdy = 1'b1;
        q4.rollback_val = 1'b1; q4.rollback_idx = 2'd2;
        #1;
        chk("rb.enq_rdy", 32'(q4.enq_rdy), 0);
        chk("rb.deq_val", 32'(q4.deq_val), 0);
        chk("rb.wr_en",   32'(q4.wr_en),   0);
        @(negedge clk);
        q4.enq_val = 1'b0; q4.deq_rdy = 1'b0; q4.rollback_val = 1'b0;
        #1;
        chk("rb.wr_idx", 32'(q4.wr_idx), 2);
        chk("rb.count",  32'(q4.count),  1);
        chk("rb.rd_idx", 32'(q4.rd_idx), 1);
        // Rolling back to the current tail leaves occupancy alone.
        @(negedge clk);
        q4.rollback_val = 1'b1; q4.rollback_idx = 2'd2;
        @(negedge clk);
        q4.rollback_val = 1'b0;
        #1;
        chk("rbnop.count",  32'(q4.count),  1);
        chk("rbnop.wr_idx", 32'(q4.wr_idx), 2);
`endif

        // SIZE=3 ring: one enqueue then six enq+deq pairs; indices cycle within 0..2.
        @(negedge clk);
        q3.enq_val = 1'b1; q3.deq_rdy = 1'b0;
        #1 chk("s3.first_wr_idx", 32'(q3.wr_idx), 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            q3.enq_val = 1'b1; q3.deq_rdy = 1'b1;
            #1;
            chk($sformatf("s3.p%0d.wr_idx", k), 32'(q3.wr_idx), 32'((k + 1) % 3));
            chk($sformatf("s3.p%0d.rd_idx", k), 32'(q3.rd_idx), 32'(k % 3));
            chk($sformatf("s3.p%0d.count",  k), 32'(q3.count),  1);
        end
        @(negedge clk);
        q3.enq_val = 1'b0; q3.deq_rdy = 1'b0;
        #1;
        chk("s3.end_wr_idx", 32'(q3.wr_idx), 1);
        chk("s3.end_rd_idx", 32'(q3.rd_idx), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
